// File: rtl/sad_frame_sequencer_pkg.sv
// Shared types and default limits for the stereo SAD frame sequencing logic.
package sad_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4
    } seq_state_t;

    localparam int unsigned DEF_SKEW_LIMIT  = 4096;
    localparam int unsigned DEF_SAD_TIMEOUT = 1048576;
    localparam int unsigned DEF_CNT_WIDTH   = 16;

endpackage

// File: rtl/sad_watchdog.sv
// Saturating cycle counter with clear/load/enable and a terminal-count flag.
module sad_watchdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic term_c
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // load starts at 1 so the count equals the number of elapsed cycles
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CW'(1);
        end else if (en && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_c = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/sad_frame_sequencer.sv
// Frame-pair controller: gates capture, launches the SAD engine, and watches
// inter-camera skew and SAD runtime.
module sad_frame_sequencer
    import sad_pkg::*;
#(
    parameter int unsigned SKEW_LIMIT  = DEF_SKEW_LIMIT,
    parameter int unsigned SAD_TIMEOUT = DEF_SAD_TIMEOUT,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 clr_err,
    input  logic                 cam1_frame_valid,
    input  logic                 cam2_frame_valid,
    input  logic                 cap1_done,
    input  logic                 cap2_done,
    input  logic                 sad_done,
    output logic                 cap_en,
    output logic                 sad_start,
    output logic                 frame_done,
    output logic                 busy,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 err_skew,
    output logic                 err_sad_timeout
);

    seq_state_t           state_q, state_d;
    logic                 got1_q, got1_d, got2_q, got2_d;
    logic                 cap_en_q, cap_en_d;
    logic                 sad_start_q, sad_start_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                 err_skew_q, err_skew_d;
    logic                 err_tmo_q, err_tmo_d;

    logic seen1, seen2;
    logic set_skew, set_tmo;
    logic skew_load, skew_en, skew_clr, skew_term_c;
    logic tmo_load, tmo_en, tmo_clr, tmo_term_c;

    always_comb begin
        state_d   = state_q;
        got1_d    = got1_q;
        got2_d    = got2_q;
        seen1     = got1_q | cap1_done;
        seen2     = got2_q | cap2_done;
        set_skew  = 1'b0;
        set_tmo   = 1'b0;
        skew_load = 1'b0;
        skew_en   = 1'b0;
        tmo_en    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) state_d = ARM;
            end
            ARM: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (!cam1_frame_valid && !cam2_frame_valid) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // a completing pulse beats skew expiry in the same cycle
                if (seen1 && seen2) begin
                    state_d = COMPUTE;
                    got1_d  = 1'b0;
                    got2_d  = 1'b0;
                end else if ((got1_q || got2_q) && skew_term_c) begin
                    set_skew = 1'b1;
                    got1_d   = 1'b0;
                    got2_d   = 1'b0;
                    state_d  = ARM;
                end else begin
                    got1_d    = seen1;
                    got2_d    = seen2;
                    skew_load = !(got1_q || got2_q) && (seen1 || seen2);
                    skew_en   = got1_q || got2_q;
                end
            end
            COMPUTE: begin
                tmo_en = 1'b1;
                // sad_start_q marks the first COMPUTE cycle, where sad_done is ignored
                if (sad_done && !sad_start_q) begin
                    state_d = DONE;
                end else if (tmo_term_c) begin
                    set_tmo = 1'b1;
                    state_d = ARM;
                end
            end
            DONE: begin
                state_d = run ? ARM : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tmo_load = (state_q == CAPTURE) && (state_d == COMPUTE);
        skew_clr = !(skew_load || skew_en);
        tmo_clr  = !(tmo_load || tmo_en);

        cap_en_d     = (state_d == CAPTURE);
        sad_start_d  = tmo_load;
        frame_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
        frame_cnt_d  = (state_q == DONE) ? frame_cnt_q + CNT_WIDTH'(1) : frame_cnt_q;
        err_skew_d   = set_skew | (err_skew_q & ~clr_err);
        err_tmo_d    = set_tmo  | (err_tmo_q  & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            got1_q       <= 1'b0;
            got2_q       <= 1'b0;
            cap_en_q     <= 1'b0;
            sad_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_cnt_q  <= '0;
            err_skew_q   <= 1'b0;
            err_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            got1_q       <= got1_d;
            got2_q       <= got2_d;
            cap_en_q     <= cap_en_d;
            sad_start_q  <= sad_start_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            frame_cnt_q  <= frame_cnt_d;
            err_skew_q   <= err_skew_d;
            err_tmo_q    <= err_tmo_d;
        end
    end

    sad_watchdog #(.LIMIT(SKEW_LIMIT)) u_skew_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (skew_clr),
        .load   (skew_load),
        .en     (skew_en),
        .term_c (skew_term_c)
    );

    sad_watchdog #(.LIMIT(SAD_TIMEOUT)) u_tmo_wd (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmo_clr),
        .load   (tmo_load),
        .en     (tmo_en),
        .term_c (tmo_term_c)
    );

    assign cap_en          = cap_en_q;
    assign sad_start       = sad_start_q;
    assign frame_done      = frame_done_q;
    assign busy            = busy_q;
    assign state           = state_q;
    assign frame_cnt       = frame_cnt_q;
    assign err_skew        = err_skew_q;
    assign err_sad_timeout = err_tmo_q;

endmodule

// File: tb/tb_sad_frame_sequencer.sv
// Scenario bench for sad_frame_sequencer with a randomized frame-pair outcome model.
module tb_sad_frame_sequencer;

    localparam int unsigned SKEW = 12;
    localparam int unsigned TMO  = 128;
    localparam int unsigned CW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, clr_err = 1'b0;
    logic fv1 = 1'b1, fv2 = 1'b1;
    logic c1 = 1'b0, c2 = 1'b0, sd = 1'b0;

    logic          cap_en, sad_start, frame_done, busy, err_skew, err_sad_timeout;
    logic [2:0]    state;
    logic [CW-1:0] frame_cnt;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_done = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    sad_frame_sequencer #(
        .SKEW_LIMIT (SKEW),
        .SAD_TIMEOUT(TMO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .clr_err         (clr_err),
        .cam1_frame_valid(fv1),
        .cam2_frame_valid(fv2),
        .cap1_done       (c1),
        .cap2_done       (c2),
        .sad_done        (sd),
        .cap_en          (cap_en),
        .sad_start       (sad_start),
        .frame_done      (frame_done),
        .busy            (busy),
        .state           (state),
        .frame_cnt       (frame_cnt),
        .err_skew        (err_skew),
        .err_sad_timeout (err_sad_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (sad_start) n_start++;
        if (frame_done) n_done++;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({cap_en, sad_start, frame_done, busy, err_skew, err_sad_timeout} !== 6'b0) begin
            failures++; $display("FAIL reset_flags got=%b expected=000000",
                {cap_en, sad_start, frame_done, busy, err_skew, err_sad_timeout});
        end
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d expected=0", state); end
        checks++;
        if (frame_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d expected=0", frame_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        run = 1'b1; fv1 = 1'b1; fv2 = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || busy !== 1'b1) begin
            failures++; $display("FAIL idle_to_arm state=%0d busy=%b expected 1/1", state, busy);
        end
        repeat (3) tick();
        fv1 = 1'b0;
        tick();
        checks++;
        if (state !== 3'd1) begin failures++; $display("FAIL arm_no_gap got=%0d expected=1", state); end
        fv2 = 1'b0;
        tick();
        checks++;
        if (state !== 3'd2 || cap_en !== 1'b1) begin
            failures++; $display("FAIL arm_to_capture state=%0d cap_en=%b expected 2/1", state, cap_en);
        end
        fv1 = 1'b1; fv2 = 1'b1;
        n_start = 0; n_done = 0;
        repeat (2) tick();
        c1 = 1'b1; tick(); c1 = 1'b0;
        repeat (9) tick();
        c2 = 1'b1; tick(); c2 = 1'b0;
        checks++;
        if (state !== 3'd3 || cap_en !== 1'b0 || sad_start !== 1'b1) begin
            failures++; $display("FAIL nominal_compute state=%0d cap_en=%b sad_start=%b expected 3/0/1",
                state, cap_en, sad_start);
        end
        repeat (99) tick();
        sd = 1'b1; tick(); sd = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || state !== 3'd4 || frame_cnt !== 3'd0) begin
            failures++; $display("FAIL nominal_done fd=%b state=%0d cnt=%0d expected 1/4/0",
                frame_done, state, frame_cnt);
        end
        tick();
        exp_frames++;
        checks++;
        if (frame_cnt !== 3'(exp_frames) || frame_done !== 1'b0 || state !== 3'd1) begin
            failures++; $display("FAIL nominal_cnt cnt=%0d fd=%b state=%0d expected %0d/0/1",
                frame_cnt, frame_done, state, exp_frames);
        end
        checks++;
        if (n_start !== 1 || n_done !== 1 || err_skew !== 1'b0 || err_sad_timeout !== 1'b0) begin
            failures++; $display("FAIL nominal_pulses starts=%0d dones=%0d errs=%b%b expected 1/1/00",
                n_start, n_done, err_skew, err_sad_timeout);
        end
    endtask

    task automatic test_skew();
        fv1 = 1'b0; fv2 = 1'b0;
        tick();
        fv1 = 1'b1; fv2 = 1'b1;
        n_start = 0;
        c2 = 1'b1; tick(); c2 = 1'b0;
        repeat (SKEW - 1) tick();
        checks++;
        if (state !== 3'd2 || err_skew !== 1'b0) begin
            failures++; $display("FAIL skew_before_limit state=%0d err=%b expected 2/0", state, err_skew);
        end
        tick();
        checks++;
        if (err_skew !== 1'b1 || state !== 3'd1 || cap_en !== 1'b0 || n_start !== 0) begin
            failures++; $display("FAIL skew_error err=%b state=%0d cap_en=%b starts=%0d expected 1/1/0/0",
                err_skew, state, cap_en, n_start);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (err_skew !== 1'b0) begin failures++; $display("FAIL skew_clear got=%b expected=0", err_skew); end
    endtask

    task automatic test_timeout();
        fv1 = 1'b0; fv2 = 1'b0; tick(); fv1 = 1'b1; fv2 = 1'b1;
        c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
        checks++;
        if (state !== 3'd3 || sad_start !== 1'b1) begin
            failures++; $display("FAIL simultaneous_caps state=%0d sad_start=%b expected 3/1", state, sad_start);
        end
        repeat (TMO - 1) tick();
        sd = 1'b1; tick(); sd = 1'b0;
        exp_frames++;
        checks++;
        if (frame_done !== 1'b1 || err_sad_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_race fd=%b err=%b expected 1/0", frame_done, err_sad_timeout);
        end
        tick();
        fv1 = 1'b0; fv2 = 1'b0; tick(); fv1 = 1'b1; fv2 = 1'b1;
        c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
        repeat (TMO - 1) tick();
        checks++;
        if (state !== 3'd3 || err_sad_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_before state=%0d err=%b expected 3/0", state, err_sad_timeout);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (err_sad_timeout !== 1'b1 || state !== 3'd1) begin
            failures++; $display("FAIL timeout_set_beats_clr err=%b state=%0d expected 1/1",
                err_sad_timeout, state);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++;
        if (err_sad_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_clear got=%b expected=0", err_sad_timeout);
        end
    endtask

    task automatic test_stray();
        fv1 = 1'b0; fv2 = 1'b0; sd = 1'b1;
        tick();
        sd = 1'b0; fv1 = 1'b1; fv2 = 1'b1;
        sd = 1'b1; tick(); sd = 1'b0;
        checks++;
        if (state !== 3'd2) begin failures++; $display("FAIL stray_sad_in_capture got=%0d expected=2", state); end
        c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
        sd = 1'b1; tick(); sd = 1'b0;
        checks++;
        if (state !== 3'd3 || frame_done !== 1'b0) begin
            failures++; $display("FAIL sad_first_cycle state=%0d fd=%b expected 3/0", state, frame_done);
        end
        c1 = 1'b1; tick(); c1 = 1'b0;
        checks++;
        if (state !== 3'd3 || cap_en !== 1'b0) begin
            failures++; $display("FAIL stray_cap_in_compute state=%0d cap_en=%b expected 3/0", state, cap_en);
        end
        sd = 1'b1; tick(); sd = 1'b0;
        exp_frames++;
        tick();
        fv1 = 1'b0; fv2 = 1'b0; tick(); fv1 = 1'b1; fv2 = 1'b1;
        c2 = 1'b1; tick(); c2 = 1'b0;
        checks++;
        if (state !== 3'd2) begin failures++; $display("FAIL stray_cap_not_latched got=%0d expected=2", state); end
        c1 = 1'b1; tick(); c1 = 1'b0;
        tick();
        sd = 1'b1; tick(); sd = 1'b0;
        exp_frames++;
        tick();
        checks++;
        if (state !== 3'd1 || frame_cnt !== 3'(exp_frames)) begin
            failures++; $display("FAIL stray_end state=%0d cnt=%0d expected 1/%0d", state, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_run_drop();
        fv1 = 1'b0; fv2 = 1'b0; tick(); fv1 = 1'b1; fv2 = 1'b1;
        c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
        run = 1'b0;
        repeat (3) tick();
        checks++;
        if (state !== 3'd3) begin failures++; $display("FAIL run_drop_no_abort got=%0d expected=3", state); end
        sd = 1'b1; tick(); sd = 1'b0;
        exp_frames++;
        checks++;
        if (frame_done !== 1'b1) begin failures++; $display("FAIL run_drop_done got=%b expected=1", frame_done); end
        tick();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            failures++; $display("FAIL run_drop_idle state=%0d busy=%b expected 0/0", state, busy);
        end
    endtask

    task automatic test_back_to_back();
        run = 1'b1; fv1 = 1'b0; fv2 = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
            tick();
            sd = 1'b1; tick(); sd = 1'b0;
            tick();
            exp_frames++;
            checks++;
            if (state !== 3'd1 || frame_cnt !== 3'(exp_frames)) begin
                failures++; $display("FAIL b2b_loop%0d state=%0d cnt=%0d expected 1/%0d",
                    i, state, frame_cnt, exp_frames % 8);
            end
        end
    endtask

    task automatic test_random();
        int unsigned d, lat, w;
        bit first2, gap, ok;
        bit exp_skew, exp_tmo;
        int exp_starts, exp_dones;
        exp_skew = 1'b0; exp_tmo = 1'b0;
        exp_starts = 0; exp_dones = 0;
        n_start = 0; n_done = 0;
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 8; k++) begin
                if (k == 7) begin
                    fv1 = 1'b0; fv2 = 1'b0;
                end else begin
                    fv1 = 1'($urandom_range(0, 1)); fv2 = 1'($urandom_range(0, 1));
                end
                gap = !fv1 && !fv2;
                tick();
                checks++;
                if (state !== (gap ? 3'd2 : 3'd1)) begin
                    failures++; $display("FAIL rnd_arm it=%0d got=%0d expected=%0d", it, state, gap ? 2 : 1);
                end
                if (gap) break;
            end
            fv1 = 1'($urandom_range(0, 1)); fv2 = 1'($urandom_range(0, 1));
            w      = $urandom_range(0, 2);
            d      = $urandom_range(0, SKEW + 2);
            lat    = $urandom_range(2, TMO + 2);
            first2 = 1'($urandom_range(0, 1));
            repeat (w) tick();
            ok = 1'b1;
            if (d == 0) begin
                c1 = 1'b1; c2 = 1'b1; tick(); c1 = 1'b0; c2 = 1'b0;
            end else begin
                if (first2) c2 = 1'b1; else c1 = 1'b1;
                tick(); c1 = 1'b0; c2 = 1'b0;
                if (d > SKEW) begin
                    repeat (SKEW) tick();
                    exp_skew = 1'b1;
                    ok = 1'b0;
                end else begin
                    repeat (d - 1) tick();
                    if (first2) c1 = 1'b1; else c2 = 1'b1;
                    tick(); c1 = 1'b0; c2 = 1'b0;
                end
            end
            if (ok) begin
                exp_starts++;
                if (lat > TMO) begin
                    repeat (TMO) tick();
                    exp_tmo = 1'b1;
                end else begin
                    repeat (lat - 1) tick();
                    sd = 1'b1; tick(); sd = 1'b0;
                    tick();
                    exp_frames++;
                    exp_dones++;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                fv1 = 1'b1;
                clr_err = 1'b1; tick(); clr_err = 1'b0;
                exp_skew = 1'b0; exp_tmo = 1'b0;
            end
            checks++;
            if (state !== 3'd1 || frame_cnt !== 3'(exp_frames) || err_skew !== exp_skew ||
                err_sad_timeout !== exp_tmo || n_start !== exp_starts || n_done !== exp_dones) begin
                failures++;
                $display("FAIL rnd_pair it=%0d d=%0d lat=%0d got st=%0d cnt=%0d es=%b et=%b ns=%0d nd=%0d expected st=1 cnt=%0d es=%b et=%b ns=%0d nd=%0d",
                    it, d, lat, state, frame_cnt, err_skew, err_sad_timeout, n_start, n_done,
                    exp_frames % 8, exp_skew, exp_tmo, exp_starts, exp_dones);
            end
        end
    endtask

    task automatic test_async_reset();
        fv1 = 1'b0; fv2 = 1'b0;
        tick();
        checks++;
        if (cap_en !== 1'b1) begin failures++; $display("FAIL ar_capture cap_en=%b expected=1", cap_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cap_en, sad_start, frame_done, busy, err_skew, err_sad_timeout} !== 6'b0 ||
            state !== 3'd0 || frame_cnt !== 3'd0) begin
            failures++; $display("FAIL ar_immediate flags=%b state=%0d cnt=%0d expected 000000/0/0",
                {cap_en, sad_start, frame_done, busy, err_skew, err_sad_timeout}, state, frame_cnt);
        end
        run = 1'b0;
        #3 rst_n = 1'b1;
        exp_frames = 0;
        tick();
        checks++;
        if (frame_cnt !== 3'd0 || state !== 3'd0) begin
            failures++; $display("FAIL ar_release cnt=%0d state=%0d expected 0/0", frame_cnt, state);
        end
        run = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || frame_cnt !== 3'd0) begin
            failures++; $display("FAIL ar_rearm state=%0d cnt=%0d expected 1/0", state, frame_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nominal();
        test_skew();
        test_timeout();
        test_stray();
        test_run_drop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_frame_sequencer.md
# sad_frame_sequencer

Top-level frame controller for the stereo disparity datapath. It gates the two camera capture paths into the image buffers and starts the SAD engine once both buffers hold a complete frame. It then waits for the engine's completion and re-arms for the next frame pair. It also enforces inter-camera skew and SAD-runtime watchdogs and exposes status and error flags.

## Interface
- SKEW_LIMIT, 4096: max clk cycles allowed between the first and second capture-complete pulse
- SAD_TIMEOUT, 1048576: max clk cycles allowed from sad_start to sad_done
- CNT_WIDTH, 16: frame counter width
- clk  in  1  system clock; all inputs synchronous to it (camera strobes synchronized upstream)
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = sequence frames continuously
- clr_err  in  1  pulse; clears sticky error flags
- cam1_frame_valid, cam2_frame_valid  in  1 each  camera frame strobes
- cap1_done, cap2_done  in  1 each  one-cycle pulse: last mean pixel of a frame written to buffer 1 / 2
- sad_done  in  1  one-cycle pulse: SAD engine has consumed both buffers
- cap_en  out  1  capture/buffer-write enable to both rgb_mean paths
- sad_start  out  1  one-cycle start pulse to SAD engine
- frame_done  out  1  one-cycle pulse per completed frame pair
- busy  out  1  state != IDLE
- state  out  3  current state encoding
- frame_cnt  out  CNT_WIDTH  completed frame pairs
- err_skew, err_sad_timeout  out  1 each  sticky error flags
- All outputs are registered. All outputs reset to 0, and state resets to IDLE.

## Operation
- States: IDLE=0, ARM=1, CAPTURE=2, COMPUTE=3, DONE=4.
- IDLE: go to ARM when run=1.
- ARM: wait until cam1_frame_valid=0 and cam2_frame_valid=0 in the same cycle, which is a frame gap on both cameras. Then go to CAPTURE. If run=0, go to IDLE.
- CAPTURE: cap_en=1. cap1_done and cap2_done are latched into got1 and got2.
  - When the first of the two is latched, the skew counter starts.
  - When both are latched, go to COMPUTE with cap_en=0. got1, got2 and the skew counter are cleared.
  - If the skew counter reaches SKEW_LIMIT before both are latched, set err_skew, clear got1/got2, and go to ARM. The partial frame is discarded.
  - If both pulses arrive in the same cycle, skew is 0 and there is no error.
- COMPUTE: sad_start=1 in the first COMPUTE cycle only. The timeout counter counts from that cycle.
  - sad_done accepted: go to DONE.
  - Counter reaches SAD_TIMEOUT: set err_sad_timeout and go to ARM.
  - sad_done in the same cycle as expiry: sad_done wins and no error is flagged.
- DONE: frame_done=1 for one cycle and frame_cnt increments, wrapping from 2^CNT_WIDTH-1 to 0. Then go to ARM if run=1, else IDLE.
- run=0 mid-CAPTURE or mid-COMPUTE does not abort. The current pair finishes, then the block goes to IDLE.
- cap*_done outside CAPTURE and sad_done outside COMPUTE (including its first cycle) are ignored.
- clr_err clears both flags. A new error set in the same cycle as clr_err wins, and that flag stays 1.
- Asynchronous reset mid-operation returns the block to IDLE immediately. All counters, latches and outputs clear, and cap_en drops asynchronously.

## Timing
- IDLE to ARM takes 1 cycle after run=1.
- ARM to CAPTURE: cap_en rises the cycle after the first clk edge where both frame_valid inputs are sampled 0.
- Second cap_done sampled at edge N: cap_en=0 and sad_start=1 from edge N+1, for one cycle.
- sad_done sampled at edge M: frame_done=1 from edge M+1. frame_cnt shows the new value from edge M+2.
- Skew counter width is clog2(SKEW_LIMIT+1). Timeout counter width is clog2(SAD_TIMEOUT+1). Both are unsigned and saturate at their limit.
- The minimum frame-pair loop, with immediate pulses, is ARM→CAPTURE→COMPUTE→DONE→ARM in 5 cycles.

## Structure
- Shared package sad_pkg holds:
  - typedef enum logic [2:0] seq_state_t, with IDLE, ARM, CAPTURE, COMPUTE, DONE
  - default SKEW_LIMIT and SAD_TIMEOUT constants, reused by the system top.
- One sub-module, sad_watchdog: a load/clear/enable counter with a terminal flag. It is instantiated twice, once for skew and once for SAD timeout.
- Everything else is a single FSM plus its output registers.

## Test plan
- Nominal frame pair: run=1, frame gap, then cap1_done at t, cap2_done at t+10, sad_done 100 cycles after sad_start. Expect a single sad_start pulse, frame_done one cycle after sad_done, frame_cnt=1, no errors.
- Skew violation: SKEW_LIMIT=8, cap1_done, no cap2_done for 8 cycles. Expect err_skew=1, return to ARM, no sad_start. clr_err then clears the flag.
- SAD timeout race: SAD_TIMEOUT=16 with sad_done at cycle 16 gives no error. Repeat with sad_done absent: err_sad_timeout=1, return to ARM.
- run dropped during COMPUTE: the pair completes, frame_done=1, then the block goes to IDLE with busy=0.
- Stray pulses: cap1_done during COMPUTE and sad_done during CAPTURE are ignored, with no state change. Simultaneous cap1_done and cap2_done give an immediate COMPUTE.
- Reset mid-CAPTURE with cap_en=1: assert rst_n=0 asynchronously. All outputs are 0 immediately, and frame_cnt stays 0 after release.
